// File: rtl/serial_subtractor.sv
// Bit-serial LSB-first W-bit subtractor: D = A - B - BIN over W cycles, START/DONE handshake.
// Optional ZERO/OVF flag outputs are enabled by defining SERIAL_SUBTRACTOR_FLAGS_EN.
module serial_subtractor #(
  parameter int W = 8
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         START,
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
  input  logic         BIN,
  output logic         BUSY,
  output logic         DONE,
  output logic [W-1:0] D,
  output logic         BOUT
`ifdef SERIAL_SUBTRACTOR_FLAGS_EN
  ,
  output logic         ZERO,
  output logic         OVF
`endif
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIN
  } state_t;

  state_t         state, state_nxt;
  logic [W-1:0]   areg, breg;
  logic [W-2:0]   sreg;
  logic [W-1:0]   res_nxt;
  logic [W-1:0]   dreg;
  logic [CW-1:0]  cnt;
  logic           br, br_nxt, bout_r;
  logic           a0, b0, dbit, last, load;
`ifdef SERIAL_SUBTRACTOR_FLAGS_EN
  logic           zero_r, ovf_r;
`endif

  // Full-subtractor cell; the result register keeps only the W-1 settled bits,
  // the incoming bit completes the word on the final step.
  always_comb begin
    a0      = areg[0];
    b0      = breg[0];
    dbit    = a0 ^ b0 ^ br;
    br_nxt  = (~a0 & b0) | (~a0 & br) | (b0 & br);
    res_nxt = {dbit, sreg};
    last    = (cnt == CW'(W - 1));
  end

  always_comb begin
    state_nxt = state;
    BUSY      = 1'b0;
    DONE      = 1'b0;
    load      = 1'b0;
    case (state)
      IDLE: begin
        if (START) begin
          load      = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        BUSY = 1'b1;
        if (last) state_nxt = FIN;
      end
      FIN: begin
        DONE = 1'b1;
        if (START) begin
          load      = 1'b1;
          state_nxt = RUN;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state  <= IDLE;
      areg   <= '0;
      breg   <= '0;
      sreg   <= '0;
      dreg   <= '0;
      cnt    <= '0;
      br     <= 1'b0;
      bout_r <= 1'b0;
`ifdef SERIAL_SUBTRACTOR_FLAGS_EN
      zero_r <= 1'b0;
      ovf_r  <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      if (load) begin
        areg <= A;
        breg <= B;
        br   <= BIN;
        cnt  <= '0;
      end else if (state == RUN) begin
        areg <= areg >> 1;
        breg <= breg >> 1;
        sreg <= res_nxt[W-1:1];
        br   <= br_nxt;
        cnt  <= cnt + CW'(1);
        if (last) begin
          dreg   <= res_nxt;
          bout_r <= br_nxt;
`ifdef SERIAL_SUBTRACTOR_FLAGS_EN
          // br here is the borrow into the MSB cell
          zero_r <= (res_nxt == '0);
          ovf_r  <= br ^ br_nxt;
`endif
        end
      end
    end
  end

  assign D    = dreg;
  assign BOUT = bout_r;
`ifdef SERIAL_SUBTRACTOR_FLAGS_EN
  assign ZERO = zero_r;
  assign OVF  = ovf_r;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: cycle-level arithmetic model (W=8),
// directed literal checks, randomized traffic, and a W=4 exhaustive sweep.
module tb_serial_subtractor;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst, start, bin;
  logic [W-1:0] a, b;
  logic         busy, done, bout;
  logic [W-1:0] d;

  logic         start4, bin4;
  logic [3:0]   a4, b4;
  logic         busy4, done4, bout4;
  logic [3:0]   d4;

`ifdef SERIAL_SUBTRACTOR_FLAGS_EN
  logic zero, ovf, zero4, ovf4;
`endif

  int vectors = 0;
  int miscompares = 0;
  bit chk = 1'b0;

  always #5 clk = ~clk;

  serial_subtractor #(.W(W)) dut (
    .CLK(clk), .RST(rst), .START(start), .A(a), .B(b), .BIN(bin),
    .BUSY(busy), .DONE(done), .D(d), .BOUT(bout)
`ifdef SERIAL_SUBTRACTOR_FLAGS_EN
    , .ZERO(zero), .OVF(ovf)
`endif
  );

  serial_subtractor #(.W(4)) dut4 (
    .CLK(clk), .RST(rst), .START(start4), .A(a4), .B(b4), .BIN(bin4),
    .BUSY(busy4), .DONE(done4), .D(d4), .BOUT(bout4)
`ifdef SERIAL_SUBTRACTOR_FLAGS_EN
    , .ZERO(zero4), .OVF(ovf4)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: an accepted op keeps the block busy W cycles, then results appear with DONE.
  int           m_rem = 0;
  logic         m_done = 1'b0, m_bout = 1'b0, m_zero = 1'b0, m_ovf = 1'b0;
  logic [W-1:0] m_d = '0;
  logic [W-1:0] p_d = '0;
  logic         p_bout = 1'b0, p_zero = 1'b0, p_ovf = 1'b0;

  always @(posedge clk) begin : model
    int diff, sa, sb, sdiff;
    if (rst) begin
      m_rem  <= 0;
      m_done <= 1'b0;
      m_d    <= '0;
      m_bout <= 1'b0;
      m_zero <= 1'b0;
      m_ovf  <= 1'b0;
    end else begin
      m_done <= (m_rem == 1);
      if (m_rem == 1) begin
        m_d    <= p_d;
        m_bout <= p_bout;
        m_zero <= p_zero;
        m_ovf  <= p_ovf;
      end
      if (start && m_rem == 0) begin
        diff   = int'(a) - int'(b) - int'(bin);
        sa     = a[W-1] ? int'(a) - (1 << W) : int'(a);
        sb     = b[W-1] ? int'(b) - (1 << W) : int'(b);
        sdiff  = sa - sb - int'(bin);
        m_rem  <= W;
        p_d    <= diff[W-1:0];
        p_bout <= (int'(a) < int'(b) + int'(bin));
        p_zero <= (diff[W-1:0] == '0);
        p_ovf  <= (sdiff < -(1 << (W - 1))) || (sdiff > (1 << (W - 1)) - 1);
      end else if (m_rem > 0) begin
        m_rem <= m_rem - 1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk) begin
      check("busy", busy, m_rem != 0);
      check("done", done, m_done);
      check("d", d, m_d);
      check("bout", bout, m_bout);
`ifdef SERIAL_SUBTRACTOR_FLAGS_EN
      check("zero", zero, m_zero);
      check("ovf", ovf, m_ovf);
`endif
    end
  end

  task automatic drive8(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tbin);
    start = 1'b1;
    a     = ta;
    b     = tb;
    bin   = tbin;
    @(negedge clk);
    start = 1'b0;
    a     = W'($urandom);
    b     = W'($urandom);
    bin   = 1'($urandom);
  endtask

  task automatic wait_done(input string name);
    bit ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (done === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check(name, ok, 1'b1);
  endtask

  initial begin
    int n;
    rst = 1'b1; start = 1'b0; a = '0; b = '0; bin = 1'b0;
    start4 = 1'b0; a4 = '0; b4 = '0; bin4 = 1'b0;
    repeat (2) @(negedge clk);
    chk = 1'b1;
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_d", d, 8'h00);
    check("rst_bout", bout, 1'b0);
    rst = 1'b0;
    @(negedge clk);

    // 100 - 37: latency and result
    drive8(8'd100, 8'd37, 1'b0);
    n = 0;
    while (busy === 1'b1 && n < 20) begin
      n++;
      @(negedge clk);
    end
    check("t1_busy_cycles", n, 8);
    check("t1_done", done, 1'b1);
    check("t1_d", d, 8'h3F);
    check("t1_bout", bout, 1'b0);

    // Underflow cases, second one launched from FIN
    drive8(8'h05, 8'h0A, 1'b0);
    wait_done("t2a_timeout");
    check("t2a_d", d, 8'hFB);
    check("t2a_bout", bout, 1'b1);
    drive8(8'h00, 8'h00, 1'b1);
    wait_done("t2b_timeout");
    check("t2b_d", d, 8'hFF);
    check("t2b_bout", bout, 1'b1);
    @(negedge clk);

    // START while busy is ignored
    drive8(8'h40, 8'h10, 1'b0);
    repeat (2) @(negedge clk);
    start = 1'b1; a = 8'hFF; b = 8'h00; bin = 1'b0;
    @(negedge clk);
    start = 1'b0;
    wait_done("t3_timeout");
    check("t3_d", d, 8'h30);
    check("t3_bout", bout, 1'b0);
    n = 0;
    repeat (12) begin
      @(negedge clk);
      if (done === 1'b1) n++;
    end
    check("t3_single_done", n, 0);

    // Reset mid-operation
    drive8(8'h22, 8'h11, 1'b1);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t4_busy", busy, 1'b0);
    check("t4_done", done, 1'b0);
    check("t4_d", d, 8'h00);
    check("t4_bout", bout, 1'b0);
    n = 0;
    repeat (12) begin
      @(negedge clk);
      if (done === 1'b1) n++;
    end
    check("t4_no_done", n, 0);
    drive8(8'd9, 8'd3, 1'b0);
    wait_done("t4b_timeout");
    check("t4b_d", d, 8'h06);
    check("t4b_bout", bout, 1'b0);
    @(negedge clk);

`ifdef SERIAL_SUBTRACTOR_FLAGS_EN
    drive8(8'h80, 8'h01, 1'b0);
    wait_done("f1_timeout");
    check("f1_d", d, 8'h7F);
    check("f1_ovf", ovf, 1'b1);
    check("f1_zero", zero, 1'b0);
    drive8(8'h55, 8'h55, 1'b0);
    wait_done("f2_timeout");
    check("f2_d", d, 8'h00);
    check("f2_zero", zero, 1'b1);
    check("f2_ovf", ovf, 1'b0);
    check("f2_bout", bout, 1'b0);
    @(negedge clk);
`endif

    // Random traffic: random STARTs (some while busy), rare resets
    repeat (3000) begin
      rst   = ($urandom_range(0, 199) == 0);
      start = ($urandom_range(0, 3) == 0);
      a     = W'($urandom);
      b     = W'($urandom);
      bin   = 1'($urandom);
      @(negedge clk);
    end
    rst = 1'b0;
    start = 1'b0;
    repeat (12) @(negedge clk);

    // W=4 exhaustive sweep, each new op issued in the FIN cycle of the last
    begin
      logic [8:0] idx;
      logic [4:0] e4;
      bit ok;
      idx = '0;
      start4 = 1'b1; a4 = idx[3:0]; b4 = idx[7:4]; bin4 = idx[8];
      @(negedge clk);
      start4 = 1'b0;
      for (int i = 0; i < 512; i++) begin
        idx = 9'(i);
        ok = 1'b0;
        for (int j = 0; j < 20; j++) begin
          if (done4 === 1'b1) begin
            ok = 1'b1;
            break;
          end
          @(negedge clk);
        end
        check("w4_timeout", ok, 1'b1);
        if (!ok) break;
        e4 = 5'((int'(idx[3:0]) - int'(idx[7:4]) - int'(idx[8])) & 31);
        check("w4_result", {bout4, d4}, e4);
        check("w4_busy_in_fin", busy4, 1'b0);
        if (i < 511) begin
          idx = 9'(i + 1);
          start4 = 1'b1; a4 = idx[3:0]; b4 = idx[7:4]; bin4 = idx[8];
          @(negedge clk);
          start4 = 1'b0;
        end
      end
    end

    chk = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
